// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed 8-digit common-anode seven-segment scan driver
//
// Purpose:
//   Latches a 32-bit hex value plus per-digit decimal points and time-multiplexes
//   them onto a shared active-low segment bus with active-low digit selects.
//   Value updates are double-buffered: a load lands in a shadow register and is
//   promoted to the displayed (active) register only on the frame wrap, so one
//   frame never mixes two values.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   load         one-cycle strobe, captures data_in/dp_in into the shadow
//   data_in      hex value, nibble k drives digit k (digit 0 = rightmost)
//   dp_in        bit k lights the decimal point of digit k
//   blank_lz     1 = suppress leading zero digits (digit 0 is never blanked)
//   en           0 = display dark while the scan keeps running
//   led_id       digit selects, active-low, at most one low
//   out_led      segments {a,b,c,d,e,f,g,dp}, active-low
//   load_pending shadow holds a value not yet shown
//   frame_done   one-cycle pulse when the scan wraps back to digit 0

module seg7_scan_driver #(
    parameter int SCAN_DIV = 100000,
    parameter int DIGITS   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] data_in,
    input  logic [7:0]  dp_in,
    input  logic        blank_lz,
    input  logic        en,
    output logic [7:0]  led_id,
    output logic [7:0]  out_led,
    output logic        load_pending,
    output logic        frame_done
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    // Only the nibbles of digits that exist take part in leading-zero detection.
    localparam logic [31:0] DIGIT_MASK = (DIGITS >= 8) ? 32'hFFFF_FFFF
                                       : 32'((33'd1 << (4 * DIGITS)) - 33'd1);

    logic [PW-1:0] prescaler;
    logic [2:0]    index;
    logic [31:0]   shadow_val;
    logic [31:0]   active_val;
    logic [7:0]    shadow_dp;
    logic [7:0]    active_dp;

    logic          tick;
    logic          wrap;
    logic [3:0]    nibble;
    logic          upper_zero;
    logic          blank;
    logic [6:0]    segs;
    logic [7:0]    next_led_id;
    logic [7:0]    next_out_led;

    // Segment pattern a..g, active-low, for one hex nibble.
    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0:    g = 7'h01;
            4'h1:    g = 7'h4F;
            4'h2:    g = 7'h12;
            4'h3:    g = 7'h06;
            4'h4:    g = 7'h4C;
            4'h5:    g = 7'h24;
            4'h6:    g = 7'h20;
            4'h7:    g = 7'h0F;
            4'h8:    g = 7'h00;
            4'h9:    g = 7'h04;
            4'hA:    g = 7'h08;
            4'hB:    g = 7'h60;
            4'hC:    g = 7'h31;
            4'hD:    g = 7'h42;
            4'hE:    g = 7'h30;
            default: g = 7'h38;
        endcase
        return g;
    endfunction

    assign tick = (prescaler == PW'(SCAN_DIV - 1));
    assign wrap = tick && (index == 3'(DIGITS - 1));

    always_comb begin
        nibble       = active_val[{index, 2'b00} +: 4];
        // Digit k is a leading zero when it and every digit above it are zero.
        upper_zero   = ((active_val & DIGIT_MASK) >> {index, 2'b00}) == 32'd0;
        blank        = blank_lz && (index != 3'd0) && upper_zero;
        segs         = blank ? 7'h7F : glyph(nibble);
        next_led_id  = 8'hFF;
        next_out_led = 8'hFF;
        if (en) begin
            next_led_id  = ~(8'd1 << index);
            next_out_led = {segs, ~active_dp[index]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler    <= '0;
            index        <= '0;
            frame_done   <= 1'b0;
            shadow_val   <= '0;
            active_val   <= '0;
            shadow_dp    <= '0;
            active_dp    <= '0;
            load_pending <= 1'b0;
            led_id       <= 8'hFF;
            out_led      <= 8'hFF;
        end else begin
            if (tick) begin
                prescaler <= '0;
                index     <= wrap ? 3'd0 : index + 3'd1;
            end else begin
                prescaler <= prescaler + PW'(1);
            end

            frame_done <= wrap;

            if (wrap && load) begin
                // A load landing on the wrap goes straight to display for the new frame.
                shadow_val   <= data_in;
                shadow_dp    <= dp_in;
                active_val   <= data_in;
                active_dp    <= dp_in;
                load_pending <= 1'b0;
            end else if (wrap) begin
                if (load_pending) begin
                    active_val <= shadow_val;
                    active_dp  <= shadow_dp;
                end
                load_pending <= 1'b0;
            end else if (load) begin
                shadow_val   <= data_in;
                shadow_dp    <= dp_in;
                load_pending <= 1'b1;
            end

            led_id  <= next_led_id;
            out_led <= next_out_led;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver

module tb_seg7_scan_driver;

    localparam int SD  = 4;
    localparam int ND  = 8;
    localparam int FRM = SD * ND;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [31:0] data_in = '0;
    logic [7:0]  dp_in = '0;
    logic        blank_lz = 1'b0;
    logic        en = 1'b1;
    logic [7:0]  led_id;
    logic [7:0]  out_led;
    logic        load_pending;
    logic        frame_done;

    seg7_scan_driver #(.SCAN_DIV(SD), .DIGITS(ND)) dut (
        .clk(clk),
        .rst(rst),
        .load(load),
        .data_in(data_in),
        .dp_in(dp_in),
        .blank_lz(blank_lz),
        .en(en),
        .led_id(led_id),
        .out_led(out_led),
        .load_pending(load_pending),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit check_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s timed out at %0t", name, $time);
    endtask

    // Reference model: position in the scan follows directly from the number of
    // clock edges since reset; the display buffer follows the load/wrap rules.
    logic [7:0]  glyph_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
    int unsigned n = 0;
    logic [31:0] m_active = '0, m_shadow = '0;
    logic [7:0]  m_active_dp = '0, m_shadow_dp = '0;
    bit          m_pending = 1'b0;
    logic [7:0]  exp_led_id = 8'hFF, exp_out_led = 8'hFF;
    bit          exp_fd = 1'b0;
    int          m_idx;
    bit          m_wrap;
    logic [7:0]  m_seg;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n = 0;
            m_active = '0; m_shadow = '0; m_active_dp = '0; m_shadow_dp = '0;
            m_pending = 1'b0;
            exp_led_id = 8'hFF; exp_out_led = 8'hFF; exp_fd = 1'b0;
        end else begin
            m_idx  = (n / SD) % ND;
            m_wrap = (n % FRM) == FRM - 1;
            m_seg  = glyph_tab[(m_active >> (4 * m_idx)) & 32'hF];
            if (blank_lz && m_idx != 0 && (m_active >> (4 * m_idx)) == 0) m_seg = 8'hFF;
            if (m_active_dp[m_idx]) m_seg = m_seg & 8'hFE;
            exp_led_id  = en ? ~(8'h01 << m_idx) : 8'hFF;
            exp_out_led = en ? m_seg : 8'hFF;
            exp_fd      = m_wrap;
            if (m_wrap && load) begin
                m_active = data_in; m_active_dp = dp_in;
                m_shadow = data_in; m_shadow_dp = dp_in;
                m_pending = 1'b0;
            end else if (m_wrap) begin
                if (m_pending) begin
                    m_active = m_shadow; m_active_dp = m_shadow_dp;
                end
                m_pending = 1'b0;
            end else if (load) begin
                m_shadow = data_in; m_shadow_dp = dp_in;
                m_pending = 1'b1;
            end
            n++;
        end
    end

    always @(negedge clk) begin
        if (check_on) begin
            chk("led_id", led_id, exp_led_id);
            chk("out_led", out_led, exp_out_led);
            chk("load_pending", load_pending, m_pending);
            chk("frame_done", frame_done, exp_fd);
        end
    end

    task automatic wait_digit(input int k, input string name);
        logic [7:0] sel;
        bit found;
        sel = ~(8'h01 << k);
        found = 1'b0;
        for (int i = 0; i < 4 * FRM; i++) begin
            @(negedge clk);
            if (led_id == sel) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) timeout(name);
    endtask

    task automatic wait_idle(input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 4 * FRM; i++) begin
            if (!load_pending) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!found) timeout(name);
        @(negedge clk);
    endtask

    task automatic load_settle(input logic [31:0] d, input logic [7:0] dp, input logic b);
        blank_lz = b;
        data_in  = d;
        dp_in    = dp;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_idle("settle");
    endtask

    typedef struct {
        logic [31:0] data;
        logic [7:0]  dp;
        logic        blz;
        int          digit;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int cnt;
        bit found;
        logic [31:0] last_d;
        logic [7:0]  last_dp;
        logic        last_b;

        vecs.push_back('{32'h89ABCDEF, 8'h00, 1'b0, 0, 8'h71});
        vecs.push_back('{32'h89ABCDEF, 8'h00, 1'b0, 1, 8'h61});
        vecs.push_back('{32'h89ABCDEF, 8'h00, 1'b0, 2, 8'h85});
        vecs.push_back('{32'h89ABCDEF, 8'h00, 1'b0, 3, 8'h63});
        vecs.push_back('{32'h89ABCDEF, 8'h00, 1'b0, 4, 8'hC1});
        vecs.push_back('{32'h89ABCDEF, 8'h00, 1'b0, 5, 8'h11});
        vecs.push_back('{32'h89ABCDEF, 8'h00, 1'b0, 6, 8'h09});
        vecs.push_back('{32'h89ABCDEF, 8'h00, 1'b0, 7, 8'h01});
        vecs.push_back('{32'h00000012, 8'h02, 1'b1, 0, 8'h25});
        vecs.push_back('{32'h00000012, 8'h02, 1'b1, 1, 8'h9E});
        vecs.push_back('{32'h00000012, 8'h02, 1'b1, 2, 8'hFF});
        vecs.push_back('{32'h00000012, 8'h02, 1'b1, 7, 8'hFF});
        vecs.push_back('{32'h76543210, 8'h00, 1'b1, 0, 8'h03});
        vecs.push_back('{32'h76543210, 8'h00, 1'b1, 3, 8'h0D});
        vecs.push_back('{32'h76543210, 8'h00, 1'b1, 4, 8'h99});
        vecs.push_back('{32'h76543210, 8'h00, 1'b1, 5, 8'h49});
        vecs.push_back('{32'h76543210, 8'h00, 1'b1, 6, 8'h41});
        vecs.push_back('{32'h76543210, 8'h00, 1'b1, 7, 8'h1F});
        vecs.push_back('{32'h00000000, 8'h01, 1'b1, 0, 8'h02});
        vecs.push_back('{32'h00000000, 8'h01, 1'b1, 3, 8'hFF});
        vecs.push_back('{32'h0000A000, 8'h80, 1'b1, 7, 8'hFE});
        vecs.push_back('{32'h0000A000, 8'h80, 1'b1, 4, 8'hFF});
        vecs.push_back('{32'h0000A000, 8'h80, 1'b1, 3, 8'h11});
        vecs.push_back('{32'h0000A000, 8'h80, 1'b1, 2, 8'h03});
        vecs.push_back('{32'h0000A000, 8'h80, 1'b0, 7, 8'h02});

        // Reset state and first digit after release
        repeat (3) @(negedge clk);
        chk("rst_led_id", led_id, 8'hFF);
        chk("rst_out_led", out_led, 8'hFF);
        chk("rst_pending", load_pending, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        rst = 1'b0;
        check_on = 1'b1;
        @(negedge clk);
        chk("first_led_id", led_id, 8'hFE);
        chk("first_out_led", out_led, 8'h03);

        // Glyph / blanking / dp table
        last_d = 32'hFFFF_FFFF; last_dp = 8'hFF; last_b = 1'b1;
        foreach (vecs[i]) begin
            if (vecs[i].data != last_d || vecs[i].dp != last_dp || vecs[i].blz != last_b) begin
                load_settle(vecs[i].data, vecs[i].dp, vecs[i].blz);
                last_d = vecs[i].data; last_dp = vecs[i].dp; last_b = vecs[i].blz;
            end
            wait_digit(vecs[i].digit, "vec_digit");
            chk($sformatf("vec%0d_out_led", i), out_led, vecs[i].exp);
        end

        // Frame period between frame_done pulses
        found = 1'b0;
        for (int i = 0; i < 2 * FRM; i++) begin
            @(negedge clk);
            if (frame_done) begin found = 1'b1; break; end
        end
        if (!found) timeout("frame_done_first");
        cnt = 0;
        found = 1'b0;
        for (int i = 0; i < 2 * FRM; i++) begin
            @(negedge clk);
            cnt++;
            if (frame_done) begin found = 1'b1; break; end
        end
        if (!found) timeout("frame_done_second");
        chk("frame_period", cnt, FRM);

        // Mid-frame load stays hidden until the wrap
        load_settle(32'h22222222, 8'h00, 1'b0);
        wait_digit(3, "mid_d3");
        data_in = 32'h11111111; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("mid_pending", load_pending, 1'b1);
        wait_digit(5, "mid_d5");
        chk("mid_old_value", out_led, 8'h25);
        wait_idle("mid_idle");
        wait_digit(0, "mid_d0");
        chk("mid_new_value", out_led, 8'h9F);

        // Load exactly on the wrap cycle
        found = 1'b0;
        for (int i = 0; i < 2 * FRM; i++) begin
            if ((n % FRM) == FRM - 1) begin found = 1'b1; break; end
            @(negedge clk);
        end
        if (!found) timeout("wrap_find");
        data_in = 32'h33333333; dp_in = 8'h00; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("wrap_pending", load_pending, 1'b0);
        chk("wrap_frame_done", frame_done, 1'b1);
        @(negedge clk);
        chk("wrap_led_id", led_id, 8'hFE);
        chk("wrap_out_led", out_led, 8'h0D);

        // Display dark for 10 cycles mid-scan
        wait_digit(2, "en_d2");
        en = 1'b0;
        @(negedge clk);
        chk("en_off_led_id", led_id, 8'hFF);
        chk("en_off_out_led", out_led, 8'hFF);
        repeat (9) @(negedge clk);
        en = 1'b1;
        repeat (FRM) @(negedge clk);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            load     = ($urandom % 8) == 0;
            data_in  = $urandom >> $urandom_range(0, 31);
            dp_in    = 8'($urandom);
            blank_lz = 1'($urandom);
            en       = ($urandom % 8) != 0;
        end
        @(negedge clk);
        load = 1'b0; en = 1'b1; blank_lz = 1'b0;
        repeat (FRM) @(negedge clk);

        // Reset during digit 5 with a pending load
        load_settle(32'h55555555, 8'h00, 1'b0);
        wait_digit(5, "rst_d5");
        data_in = 32'h44444444; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("rst_mid_pending", load_pending, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_led_id", led_id, 8'hFF);
        chk("rst_mid_out_led", out_led, 8'hFF);
        chk("rst_mid_pending_clr", load_pending, 1'b0);
        chk("rst_mid_frame_done", frame_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_after_led_id", led_id, 8'hFE);
        chk("rst_after_out_led", out_led, 8'h03);
        chk("rst_after_pending", load_pending, 1'b0);
        repeat (2 * FRM) @(negedge clk);

        check_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
